// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream FIFO transmit front end.
package axis_pkg;
   localparam int DWIDTH_DEF = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t EMPTY = 2'd0;
   localparam occ_t FULL  = 2'd2;

   // Beat counter width: a 1-beat packet still needs one counter bit.
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready buffer: an output register plus one skid register.
// Absorbs the word that was already in flight when the sink stalls.
module axis_skid_buffer
   import axis_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output occ_t              occ
);
   logic [DWIDTH-1:0] skid_q;
   logic              hs;

   assign out_valid = (occ != EMPTY);
   assign hs        = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ <= EMPTY;
      end else begin
         case ({in_valid, hs})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Data registers carry no reset; occ alone says what is meaningful.
   always_ff @(posedge clk) begin
      if (in_valid && (occ == EMPTY || (hs && occ == 2'd1)))
         out_data <= in_data;
      else if (hs && occ == FULL)
         out_data <= skid_q;

      if (in_valid && ((occ == 2'd1 && !hs) || (occ == FULL && hs)))
         skid_q <= in_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_valid && occ == FULL && !hs));
endmodule

// File: rtl/axis_fifo_tx.sv
// Drains a registered-read FIFO onto an AXI-Stream master port, framing
// fixed-length packets with tlast.
module axis_fifo_tx
   import axis_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int PKT_LEN = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DWIDTH-1:0] fifo_dout,
   output logic [DWIDTH-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy
);
   localparam int            CW        = cnt_w(PKT_LEN);
   localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

   occ_t          occ;
   logic          inflight;
   logic          hs;
   logic [2:0]    credit;
   logic [CW-1:0] beat_cnt;

   assign hs = m_axis_tvalid & m_axis_tready;

   // Words committed to the buffer after this edge; hs only occurs with occ>=1.
   assign credit     = 3'(occ) + 3'(inflight) - 3'(hs);
   assign fifo_rd_en = rst_n & en & ~fifo_empty & (credit < 3'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) inflight <= 1'b0;
      else        inflight <= fifo_rd_en;
   end

   axis_skid_buffer #(.DWIDTH(DWIDTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inflight),
      .in_data   (fifo_dout),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_data  (m_axis_tdata),
      .occ       (occ)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         beat_cnt <= '0;
      else if (hs)
         beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
   end

   assign m_axis_tlast = m_axis_tvalid & (beat_cnt == LAST_BEAT);
   assign busy         = (occ != EMPTY) | inflight;
endmodule

// File: tb/tb_axis_fifo_tx.sv
// Scoreboard bench: three instances (PKT_LEN 8/3/1) share one FIFO model and
// identical stimulus; words are queued on push and checked on each handshake.
module tb_axis_fifo_tx;
   localparam int DW = 16;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tready = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic fifo_empty;
   logic rd8, rd3, rd1, v8, v3, v1, l8, l3, l1, b8, b3, b1;
   logic [DW-1:0] d8, d3, d1;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int n_push = 0, n_pop = 0;
   int n_chk = 0, n_err = 0, beat_i = 0;
   logic stall_v = 1'b0, stall_l = 1'b0;
   logic [DW-1:0] stall_d = '0, exp_w;
   logic [3:0] tpat = 4'b1001;

   always #5 clk = ~clk;

   assign fifo_empty = (n_push == n_pop);

   axis_fifo_tx #(.DWIDTH(DW), .PKT_LEN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(rd8),
      .fifo_dout(fifo_dout), .m_axis_tdata(d8), .m_axis_tvalid(v8),
      .m_axis_tready(tready), .m_axis_tlast(l8), .busy(b8));
   axis_fifo_tx #(.DWIDTH(DW), .PKT_LEN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(rd3),
      .fifo_dout(fifo_dout), .m_axis_tdata(d3), .m_axis_tvalid(v3),
      .m_axis_tready(tready), .m_axis_tlast(l3), .busy(b3));
   axis_fifo_tx #(.DWIDTH(DW), .PKT_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(rd1),
      .fifo_dout(fifo_dout), .m_axis_tdata(d1), .m_axis_tvalid(v1),
      .m_axis_tready(tready), .m_axis_tlast(l1), .busy(b1));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      n_push++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      n_push = n_pop;
      beat_i = 0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   // Wait until everything popped has left the DUTs and nothing poppable remains.
   task automatic drain(input string tag);
      int k = 0;
      while (!(exp_q.size() == fifo_q.size() && !b8 && !b3 && !b1 &&
               (!en || fifo_q.size() == 0)) && k < 200) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < 200), 32'd1);
   endtask

   // Registered-read FIFO model: data appears the cycle after a pop.
   always @(posedge clk) begin
      if (rd8) begin
         chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
         n_pop <= n_pop + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_v = 1'b0;
      end else begin
         if (stall_v) begin
            chk("hold_valid", 32'(v8), 32'd1);
            chk("hold_data", 32'(d8), 32'(stall_d));
            chk("hold_last", 32'(l8), 32'(stall_l));
         end
         if (v8 && tready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_w = exp_q.pop_front();
               chk("data8", 32'(d8), 32'(exp_w));
               chk("data3", 32'(d3), 32'(exp_w));
               chk("data1", 32'(d1), 32'(exp_w));
               chk("last8", 32'(l8), 32'((beat_i % 8) == 7));
               chk("last3", 32'(l3), 32'((beat_i % 3) == 2));
               chk("last1", 32'(l1), 32'd1);
               chk("valid31", 32'({v3, v1}), 32'd3);
               chk("rd_match", 32'({rd3, rd1}), 32'({rd8, rd8}));
            end
            beat_i++;
         end
         stall_v = v8 && !tready;
         stall_d = d8;
         stall_l = l8;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int vc;
      // Reset holds everything idle even with data available and en high
      en = 1'b1;
      tready = 1'b1;
      push(16'hAAAA);
      tick();
      tick();
      @(negedge clk);
      chk("rst_rd_en", 32'(rd8), 32'd0);
      chk("rst_valid", 32'(v8), 32'd0);
      chk("rst_last", 32'(l8), 32'd0);
      chk("rst_busy", 32'(b8), 32'd0);
      @(posedge clk); #1;
      en = 1'b0;
      do_reset(1);

      // Preloaded burst at full rate
      for (int i = 1; i <= 8; i++) push(DW'(i));
      tick();
      @(negedge clk);
      chk("en_low_no_pop", 32'(rd8), 32'd0);
      chk("idle_busy", 32'(b8), 32'd0);
      @(posedge clk); #1;
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("burst_rd_en", 32'(rd8), 32'd1);
         chk("burst_valid", 32'(v8), 32'(i >= 2));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("burst_rd_stop", 32'(rd8), 32'd0);
      @(posedge clk); #1;
      drain("burst_drain");

      // Backpressure pattern 1,0,0,1,...
      for (int i = 9; i <= 16; i++) push(DW'(i));
      for (int k = 0; k < 300 && !(exp_q.size() == 0 && !b8); k++) begin
         tready = tpat[k % 4];
         tick();
      end
      chk("bp_drain", 32'(exp_q.size() == 0 && !b8), 32'd1);
      tready = 1'b1;

      // Reset mid-packet with the buffer full
      for (int i = 0; i < 5; i++) push(16'h0100 + DW'(i));
      drain("pre_rst_drain");
      chk("pre_rst_cnt", 32'(dut8.beat_cnt), 32'd5);
      tready = 1'b0;
      for (int i = 0; i < 3; i++) push(16'h0200 + DW'(i));
      repeat (5) tick();
      @(negedge clk);
      chk("pre_rst_occ", 32'(dut8.occ), 32'd2);
      chk("pre_rst_valid", 32'(v8), 32'd1);
      @(posedge clk); #1;
      do_reset(1);
      @(negedge clk);
      chk("post_rst_valid", 32'(v8), 32'd0);
      chk("post_rst_busy", 32'(b8), 32'd0);
      @(posedge clk); #1;
      tready = 1'b1;
      for (int i = 0; i < 8; i++) push(16'h0300 + DW'(i));
      drain("post_rst_pkt");

      // Three-beat framing: 7 beats, then one more
      do_reset(2);
      for (int i = 0; i < 7; i++) push(16'h0400 + DW'(i));
      drain("pk3_drain");
      chk("pk3_cnt_after7", 32'(dut3.beat_cnt), 32'd1);
      push(16'h0407);
      drain("pk3_extra");

      // en dropped right after a pop while one word is buffered
      en = 1'b0;
      tready = 1'b0;
      tick();
      push(16'h0500);
      en = 1'b1;
      @(negedge clk);
      chk("en_pop_a", 32'(rd8), 32'd1);
      @(posedge clk); #1;
      en = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("en_occ1", 32'(dut8.occ), 32'd1);
      chk("en_valid", 32'(v8), 32'd1);
      @(posedge clk); #1;
      push(16'h0501);
      en = 1'b1;
      @(negedge clk);
      chk("en_pop_b", 32'(rd8), 32'd1);
      @(posedge clk); #1;
      push(16'h0502);
      en = 1'b0;
      @(negedge clk);
      chk("en_gate", 32'(rd8), 32'd0);
      chk("en_busy", 32'(b8), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("en_occ2", 32'(dut8.occ), 32'd2);
      @(posedge clk); #1;
      tready = 1'b1;
      drain("en_drain");
      @(negedge clk);
      chk("en_busy_low", 32'(b8), 32'd0);
      chk("en_hold_fifo", 32'(rd8), 32'd0);
      @(posedge clk); #1;
      en = 1'b1;
      drain("en_resume");

      // Sparse FIFO: one word every 4 cycles, exactly one valid cycle each
      for (int w = 0; w < 6; w++) begin
         push(16'h0600 + DW'(w));
         vc = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vc += int'(v8);
            @(posedge clk); #1;
         end
         chk("sparse_vcyc", 32'(vc), 32'd1);
      end
      drain("sparse_drain");
      chk("final_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axis_fifo_tx.md
Name: axis_fifo_tx

Overview:
AXI-Stream master (transmit) front end that drains a synchronous FIFO with a registered read port and presents the words on an AXI-Stream master interface. It sits on the read side of the stream FIFO and handles the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains 1 beat/cycle under full backpressure compliance. It frames the stream into fixed-length packets via tlast.

Parameters:
DWIDTH, 16, data width; must match the FIFO DWIDTH.
PKT_LEN, 8, beats per packet; tlast is asserted on beat PKT_LEN-1; valid range 1..65535.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
en  input  1  when high, the block may pop the FIFO; when low, no new pops, buffered data still drains
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop request; fifo_dout is valid on the cycle after a pop
fifo_dout  input  DWIDTH  FIFO read data (registered)
m_axis_tdata  output  DWIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready from the sink
m_axis_tlast  output  1  last beat of packet
busy  output  1  high while any word is in flight or buffered

Behaviour:
- Reset: rst_n is synchronous and active-low on clk. While rst_n=0: tvalid=0, tlast=0, fifo_rd_en=0, busy=0, buffer occupancy=0, in-flight flag=0, beat counter=0. tdata is don't-care.
- Reset mid-packet: all buffered and in-flight words are discarded. The beat counter restarts at 0.
- Pop rule: fifo_rd_en = rst_n & en & !fifo_empty & ((occ + inflight - hs) < 2).
  - occ is the buffered word count, 0..2.
  - inflight is a 1-bit register set on the cycle after fifo_rd_en=1.
  - hs = m_axis_tvalid & m_axis_tready.
- Capture: on a cycle with inflight=1, fifo_dout is written into the buffer. It goes to the output register if that register is empty or being drained this cycle; otherwise it goes to the skid register.
- Buffer:
  - The output register drives tdata and tvalid.
  - On hs, the skid word (if any) moves to the output register on the same edge.
  - Word order is preserved strictly. The buffer never overflows; a capture when occ=2 with no hs is an assertion failure.
- AXI rules:
  - tvalid does not depend combinationally on tready.
  - Once tvalid=1, it stays high and tdata/tlast stay stable until hs.
- Latency: the first word appears with tvalid=1 two cycles after fifo_empty falls (pop in cycle N, capture at edge N+1, tvalid in N+2) when en=1 and the buffer is empty.
- Throughput: with tready held high and the FIFO non-empty, one beat is transferred per cycle continuously.
- Framing:
  - beat_cnt has width max(1, $clog2(PKT_LEN)) and increments on hs.
  - It wraps to 0 on the hs where beat_cnt == PKT_LEN-1.
  - tlast = tvalid & (beat_cnt == PKT_LEN-1). With PKT_LEN=1, every beat has tlast=1.
- en deassert: fifo_rd_en drops in the same cycle. An in-flight word is still captured, and all buffered words still drain. beat_cnt is preserved across en toggles.
- FIFO empty mid-stream: tvalid drops after the buffer drains. No bubble word is ever emitted.
- Simultaneous capture and hs at occ=1: the output register takes the incoming word, and occ stays 1.
- busy = (occ != 0) | inflight.

Decomposition:
- Package axis_pkg holds:
  - default DWIDTH
  - the beat counter width function max(1, $clog2(n))
  - the occupancy constants EMPTY=0 and FULL=2
- One sub-module, axis_skid_buffer: a 2-entry valid/ready buffer with in_valid/in_data/out_valid/out_ready/out_data and an occ output. axis_fifo_tx contains the pop credit logic, the inflight flag, and the tlast counter around it.

Test Plan:
- FIFO preloaded with 0x0001..0x0008, en=1, tready=1 -> tvalid first high 2 cycles after the first pop. 8 consecutive beats 0x0001..0x0008 are transferred, tlast only on 0x0008, fifo_rd_en high for 8 consecutive cycles.
- Same data with tready toggling 1,0,0,1,... -> tdata/tlast stable during every tready=0 cycle, no loss or duplication, order preserved, occ never exceeds 2.
- PKT_LEN=3, 7 words streamed -> tlast on beats 3 and 6. beat_cnt=1 after the 7th beat, and the next word (when supplied) carries tlast=0.
- en dropped the cycle after a pop, with tready=0 holding 1 word buffered -> fifo_rd_en=0 immediately, the in-flight word is captured (occ=2), then both words drain once tready=1 and busy falls to 0.
- rst_n pulsed low for 1 cycle mid-packet (beat_cnt=5, occ=2) -> the cycle after the reset edge shows tvalid=0 and busy=0. The next packet's tlast arrives on its 8th beat.
- PKT_LEN=1 with a sparse FIFO (one word every 4 cycles) -> every beat has tlast=1, tvalid drops between words, no extra beats.
